// File: rtl/dm_pkg.sv
// Shared encodings for the sized data memory: access sizes, controller states
// and the per-size alignment mask used by the error decode.
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    IDLE = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } state_e;

  localparam int WAIT_W = 4;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [1:0] align_mask(input size_e sz);
    case (sz)
      SZ_HALF: return 2'b01;
      SZ_WORD: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_sized_ctrl_if.sv
// Request/response bundle between the pipeline and the sized data memory.
interface dm_sized_ctrl_if;
  import dm_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  size_e       req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/dm_lane_fmt.sv
// Combinational lane formatter: big-endian load extraction/extension, store
// byte enables and lane replication, and access error decode.
module dm_lane_fmt
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  size_e       size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  output logic        err,
  output logic [31:0] load_data,
  output logic [3:0]  be,
  output logic [31:0] wlane
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    err = (size == SZ_RSVD)
        || ((addr[1:0] & align_mask(size)) != 2'b00)
        || ((addr >> ADDR_W) != 32'd0);

    // rd_word[31:24] holds the byte at the lowest address of the word
    case (addr[1:0])
      2'd0:    sel_byte = rd_word[31:24];
      2'd1:    sel_byte = rd_word[23:16];
      2'd2:    sel_byte = rd_word[15:8];
      default: sel_byte = rd_word[7:0];
    endcase
    sel_half = addr[1] ? rd_word[15:0] : rd_word[31:16];

    load_data = 32'd0;
    be        = 4'b0000;
    wlane     = 32'd0;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sel_byte[7] & ~uns}}, sel_byte};
        be        = 4'b1000 >> addr[1:0];
        wlane     = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        load_data = {{16{sel_half[15] & ~uns}}, sel_half};
        be        = addr[1] ? 4'b0011 : 4'b1100;
        wlane     = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        load_data = rd_word;
        be        = 4'b1111;
        wlane     = wdata;
      end
      default: ;
    endcase

    if (err) begin
      load_data = 32'd0;
      be        = 4'b0000;
    end
  end

endmodule

// File: rtl/dm_sized_ctrl.sv
// Byte-addressed big-endian data memory with valid/ready requests, fixed wait
// states, error reporting and a word-per-cycle clear after reset.
module dm_sized_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           rst,
  dm_sized_ctrl_if.slave bus
);

  localparam int IDX_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;
  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e            state_reg, state_next;
  logic [IDX_W-1:0]  cnt_reg;
  logic [WAIT_W-1:0] wait_reg;
  logic              cap_we_reg;
  logic              cap_uns_reg;
  size_e             cap_size_reg;
  logic [31:0]       cap_addr_reg;
  logic [31:0]       cap_wdata_reg;
  logic [31:0]       rsp_rdata_reg;
  logic              rsp_err_reg;
  logic              init_done_reg;

  logic              handshake;
  logic              do_access;
  logic              mem_clear;
  logic [3:0]        mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [IDX_W-1:0]  mem_ridx;
  logic [31:0]       mem_wdata;
  logic [31:0]       rd_word;

  logic              fmt_err;
  logic [31:0]       fmt_load;
  logic [3:0]        fmt_be;
  logic [31:0]       fmt_wlane;

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    logic [31:0] s;
    s = a >> 2;
    return s[IDX_W-1:0];
  endfunction

  always_comb begin
    state_next = state_reg;
    handshake  = 1'b0;
    do_access  = 1'b0;
    mem_clear  = 1'b0;
    case (state_reg)
      INIT: begin
        mem_clear = 1'b1;
        if (cnt_reg == LAST_IDX) state_next = IDLE;
      end
      IDLE: begin
        if (bus.req_valid) begin
          handshake  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (wait_reg == '0) begin
          do_access  = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= INIT;
      cnt_reg       <= '0;
      wait_reg      <= '0;
      cap_we_reg    <= 1'b0;
      cap_uns_reg   <= 1'b0;
      cap_size_reg  <= SZ_BYTE;
      cap_addr_reg  <= 32'd0;
      cap_wdata_reg <= 32'd0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (mem_clear) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == LAST_IDX) init_done_reg <= 1'b1;
      end
      if (handshake) begin
        cap_we_reg    <= bus.req_we;
        cap_uns_reg   <= bus.req_unsigned;
        cap_size_reg  <= bus.req_size;
        cap_addr_reg  <= bus.req_addr;
        cap_wdata_reg <= bus.req_wdata;
        wait_reg      <= WAIT_W'(WAIT_STATES);
      end else if (state_reg == WAIT && wait_reg != '0) begin
        wait_reg <= wait_reg - 1'b1;
      end
      if (do_access) begin
        rsp_rdata_reg <= cap_we_reg ? 32'd0 : fmt_load;
        rsp_err_reg   <= fmt_err;
      end
    end
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.init_done = init_done_reg;

  dm_lane_fmt #(.ADDR_W(ADDR_W)) u_fmt (
    .size      (cap_size_reg),
    .uns       (cap_uns_reg),
    .addr      (cap_addr_reg),
    .wdata     (cap_wdata_reg),
    .rd_word   (rd_word),
    .err       (fmt_err),
    .load_data (fmt_load),
    .be        (fmt_be),
    .wlane     (fmt_wlane)
  );

  // The read word is registered at the accepting edge from the incoming
  // address, so it is ready long before the access edge.
  assign mem_ridx  = word_idx(bus.req_addr);
  assign mem_widx  = mem_clear ? cnt_reg : word_idx(cap_addr_reg);
  assign mem_wdata = mem_clear ? 32'd0 : fmt_wlane;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      logic [7:0] bank [2**IDX_W];
      logic [7:0] rd_byte_reg;

      assign mem_we[gi] = mem_clear | (do_access & cap_we_reg & fmt_be[3-gi]);

      always_ff @(posedge clk) begin
        if (mem_we[gi]) bank[mem_widx] <= mem_wdata[31-8*gi -: 8];
        if (state_reg == IDLE) rd_byte_reg <= bank[mem_ridx];
      end

      assign rd_word[31-8*gi -: 8] = rd_byte_reg;
    end
  endgenerate

endmodule
